// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, byte/ACK geometry, codec address.
package i2c_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned ACK_SLOT      = 8;
    localparam logic [6:0]  I2C_CODEC_ADDR = 7'h1A;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_WRITE_ACK = 3'd4;
    localparam logic [2:0] ST_READ      = 3'd5;
    localparam logic [2:0] ST_READ_ACK  = 3'd6;
    localparam logic [2:0] ST_IGNORE    = 3'd7;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA to clk and produces registered SCL edge and START/STOP strobes.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic r_sda;
    logic r_scl_rise;
    logic r_scl_fall;
    logic r_start_det;
    logic r_stop_det;
    logic w_scl_new;
    logic w_scl_old;
    logic w_sda_new;
    logic w_sda_old;

    // Edges compare the two oldest synchroniser stages.
    assign w_scl_new = r_scl_sync[SYNC_STAGES-2];
    assign w_scl_old = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_new = r_sda_sync[SYNC_STAGES-2];
    assign w_sda_old = r_sda_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_sync  <= '1;
            r_sda_sync  <= '1;
            r_sda       <= 1'b1;
            r_scl_rise  <= 1'b0;
            r_scl_fall  <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_sda       <= w_sda_new;
            r_scl_rise  <= w_scl_new & ~w_scl_old;
            r_scl_fall  <= ~w_scl_new & w_scl_old;
            r_start_det <= w_sda_old & ~w_sda_new & w_scl_new & w_scl_old;
            r_stop_det  <= ~w_sda_old & w_sda_new & w_scl_new & w_scl_old;
        end
    end

    assign o_sda       = r_sda;
    assign o_scl_rise  = r_scl_rise;
    assign o_scl_fall  = r_scl_fall;
    assign o_start_det = r_start_det;
    assign o_stop_det  = r_stop_det;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, ACK, write-byte delivery and read-byte request handshake.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDR        = I2C_CODEC_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic w_sda, w_rise, w_fall, w_start, w_stop;
    logic [7:0] w_shift_in;

    logic [2:0] r_state,   w_state_nxt;
    logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift,   w_shift_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic r_rw,       w_rw_nxt;
    logic r_sda_oe,   w_sda_oe_nxt;
    logic r_busy,     w_busy_nxt;
    logic r_first,    w_first_nxt;
    logic r_rx_valid, w_rx_valid_nxt;
    logic r_rx_first, w_rx_first_nxt;
    logic r_tx_req,   w_tx_req_nxt;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .reset       (reset),
        .i_scl       (i2c_sclk),
        .i_sda       (i2c_sdat),
        .o_sda       (w_sda),
        .o_scl_rise  (w_rise),
        .o_scl_fall  (w_fall),
        .o_start_det (w_start),
        .o_stop_det  (w_stop)
    );

    assign w_shift_in = {r_shift[6:0], w_sda};

    // Next-state logic; in the ACK states r_sda_oe marks whether the ACK is already on the bus.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_rx_data_nxt  = r_rx_data;
        w_rw_nxt       = r_rw;
        w_sda_oe_nxt   = r_sda_oe;
        w_busy_nxt     = r_busy;
        w_first_nxt    = r_first;
        w_rx_valid_nxt = 1'b0;
        w_rx_first_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;
        if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: if (w_rise) begin
                    w_shift_nxt   = w_shift_in;
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'(BITS_PER_BYTE - 1)) begin
                        if (w_shift_in[7:1] == ADDR) begin
                            w_state_nxt = ST_ADDR_ACK;
                            w_busy_nxt  = 1'b1;
                            w_rw_nxt    = w_sda;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: if (w_rise) begin
                    w_tx_req_nxt = r_rw;
                end else if (w_fall) begin
                    if (!r_sda_oe) begin
                        w_sda_oe_nxt = 1'b1;
                    end else if (!r_rw) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                        w_first_nxt   = 1'b1;
                        w_state_nxt   = ST_WRITE;
                    end else begin
                        w_shift_nxt   = tx_data;
                        w_sda_oe_nxt  = ~tx_data[7];
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = ST_READ;
                    end
                end
                ST_WRITE: if (w_rise) begin
                    w_shift_nxt   = w_shift_in;
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'(BITS_PER_BYTE - 1)) begin
                        w_rx_data_nxt  = w_shift_in;
                        w_rx_valid_nxt = 1'b1;
                        w_rx_first_nxt = r_first;
                        w_first_nxt    = 1'b0;
                        w_state_nxt    = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: if (w_fall) begin
                    if (!r_sda_oe) begin
                        w_sda_oe_nxt = 1'b1;
                    end else begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = ST_WRITE;
                    end
                end
                ST_READ: if (w_rise) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                end else if (w_fall) begin
                    if (r_bit_cnt == 4'(ACK_SLOT)) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = ST_READ_ACK;
                    end else begin
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                        w_sda_oe_nxt = ~r_shift[6];
                    end
                end
                ST_READ_ACK: if (w_rise) begin
                    if (w_sda) begin
                        w_state_nxt = ST_IGNORE;
                    end else begin
                        w_tx_req_nxt = 1'b1;
                    end
                end else if (w_fall) begin
                    w_shift_nxt   = tx_data;
                    w_sda_oe_nxt  = ~tx_data[7];
                    w_bit_cnt_nxt = 4'd0;
                    w_state_nxt   = ST_READ;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_first    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_tx_req   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rw       <= w_rw_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_first    <= w_first_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_first <= w_rx_first_nxt;
            r_tx_req   <= w_tx_req_nxt;
        end
    end

    assign i2c_sdat = r_sda_oe ? 1'b0 : 1'bz;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_first = r_rx_first;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;

endmodule
